// File: rtl/serial_tx_if.sv
// rtl/serial_tx_if.sv - byte-side push/status bundle for the serial_tx UART transmitter
//
// Signals:
//   tx_byte     master->slave  8            byte to send, sampled on an accepted push
//   tx_send     master->slave  1            push strobe, one byte per cycle while high
//   tx_ready    slave->master  1            FIFO not full
//   tx_busy     slave->master  1            frame in progress or FIFO non-empty
//   tx_count    slave->master  DEPTH_LOG2+1 FIFO occupancy
//   tx_overflow slave->master  1            sticky rejected-push flag
interface serial_tx_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          tx_byte;
    logic                tx_send;
    logic                tx_ready;
    logic                tx_busy;
    logic [DEPTH_LOG2:0] tx_count;
    logic                tx_overflow;

    modport master (
        output tx_byte, tx_send,
        input  tx_ready, tx_busy, tx_count, tx_overflow
    );

    modport slave (
        input  tx_byte, tx_send,
        output tx_ready, tx_busy, tx_count, tx_overflow
    );
endinterface

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - FIFO-buffered 8N1/8E1 UART transmitter driving ftdi_tx
//
// Build option: SERIAL_TX_PARITY_EN adds an even-parity bit (8E1, 11-bit frame);
// left undefined the frame is 8N1 (10 bits).
//
// Ports:
//   clk    in   serial clock (12 MHz)
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of serial_tx_if (tx_byte/tx_send in; tx_ready/tx_busy/
//               tx_count/tx_overflow out)
//   tx     out  registered serial line, idle high
module serial_tx #(
    parameter int CLK_DIV    = 52,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_tx_if.slave   bus,
    output logic         tx
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(CLK_DIV);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef SERIAL_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;

    logic [2:0]            r_state;
    logic [CW-1:0]         r_baud;
    logic [2:0]            r_bit_cnt;
    logic [7:0]            r_shift;
    logic                  r_tx;
`ifdef SERIAL_TX_PARITY_EN
    logic                  r_parity;
`endif

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_bit_end;
    logic [7:0]            w_head;

    // Acceptance uses the pre-edge count, so a full FIFO rejects even when a
    // pop happens on the same edge.
    assign w_full    = (r_count == (DEPTH_LOG2+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = bus.tx_send & ~w_full;
    assign w_bit_end = (r_baud == CW'(CLK_DIV - 1));
    assign w_head    = r_mem[r_rd_ptr];

    // The FSM pops when leaving IDLE or at the end of a stop bit; both paths
    // start a new frame immediately, giving gapless back-to-back frames.
    assign w_pop = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.tx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            if (bus.tx_send && w_full) begin
                r_overflow <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            // Every state entry other than IDLE->START happens on a bit boundary,
            // so wrapping at the boundary restarts the count on each entry.
            r_baud <= w_bit_end ? '0 : r_baud + CW'(1);
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    if (!w_empty) begin
                        r_state   <= S_START;
                        r_shift   <= w_head;
                        r_bit_cnt <= '0;
                        r_tx      <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
                        r_parity  <= ^w_head;
`endif
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        if (!w_empty) begin
                            r_state   <= S_START;
                            r_shift   <= w_head;
                            r_bit_cnt <= '0;
                            r_tx      <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
                            r_parity  <= ^w_head;
`endif
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx              = r_tx;
    assign bus.tx_ready    = ~w_full;
    assign bus.tx_count    = r_count;
    assign bus.tx_overflow = r_overflow;
    assign bus.tx_busy     = (r_state != S_IDLE) | ~w_empty;
endmodule
